vx_sau_feeder: RTL and testbench

VX_SAU_FEEDER -- requirements
Module: VX_sau_feeder

---
 rtl/vx_sau_feeder_pkg.sv | 20 ++
 rtl/vx_sau_feeder_diag_sel.sv | 35 +++
 rtl/vx_sau_feeder.sv | 198 +++++++++++++++++++
 tb/tb_vx_sau_feeder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_sau_feeder_pkg.sv
// Purpose : shared types and sizing helpers for the systolic-array feeder.
// Latency : n/a (package).
// Backpressure : n/a (package).
// Contents: feeder FSM state enum and the counter-width helper.
package VX_sau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } sau_state_e;

  // One counter serves as row index (0..N-1), FEED time (0..2N-2) and
  // DRAIN time (0..N-1), so it must hold values up to 2N-2.
  function automatic int sau_cnt_w(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/vx_sau_feeder_diag_sel.sv
// Purpose : per-lane diagonal selector, lane K picks A[K][t-K] and B[t-K][K], else zero.
// Latency : combinational.
// Backpressure : none, pure function of its inputs.
// Ports: a_mat/b_mat  flat N x N matrices, element (r,c) at bits (r*N+c)*DW;
//        t            current wavefront index;
//        a_lane/b_lane selected element for lane K.
module VX_sau_diag_sel
  import VX_sau_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int K  = 0,
  parameter int CW = sau_cnt_w(N)
) (
  input  logic [N*N*DW-1:0] a_mat,
  input  logic [N*N*DW-1:0] b_mat,
  input  logic [CW-1:0]     t,
  output logic [DW-1:0]     a_lane,
  output logic [DW-1:0]     b_lane
);

  // Scanning c with constant indices keeps the mux structure static: lane K
  // is non-zero only when t == K + c for some in-range column c.
  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int c = 0; c < N; c++) begin
      if (int'(t) == K + c) begin
        a_lane = a_mat[(K*N + c)*DW +: DW];
        b_lane = b_mat[(c*N + K)*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/vx_sau_feeder.sv
// Purpose : loads N row pairs of A/B, then feeds skewed wavefronts to a systolic array.
// Latency : FEED starts the cycle after the N-th beat; 2N-1 FEED + N DRAIN cycles, then done.
// Backpressure : load_ready high only in IDLE/LOAD; load_valid pauses stall loading without loss.
// Ports: clk/reset (sync, active-high); load_valid/load_ready/load_row_a/load_row_b row
//        handshake; in_a/in_b/feed_valid wavefront output; busy, done status.
// Optional: define SAU_FEEDER_PERF_EN to add perf_busy_cycles (32-bit occupancy counter).
module vx_sau_feeder
  import VX_sau_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_SIZE   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] load_row_a,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] load_row_b,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] in_a,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] in_b,
  output logic                             feed_valid,
  output logic                             busy,
  output logic                             done
`ifdef SAU_FEEDER_PERF_EN
  ,
  output logic [31:0]                      perf_busy_cycles
`endif
);

  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_SIZE;
  localparam int RW = N * DW;
  localparam int MW = N * N * DW;
  localparam int CW = sau_cnt_w(N);

  localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);
  localparam logic [CW-1:0] T_LAST   = CW'(2 * N - 2);

  sau_state_e    st_q, st_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] t_q, t_d;
  logic [MW-1:0] a_q, a_d;
  logic [MW-1:0] b_q, b_d;
  logic [RW-1:0] in_a_q, in_a_d;
  logic [RW-1:0] in_b_q, in_b_d;
  logic          feed_valid_q, feed_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [RW-1:0] sel_a, sel_b;
  logic          load_fire;

  assign load_ready = (st_q == ST_IDLE) || (st_q == ST_LOAD);
  assign load_fire  = load_valid && load_ready;

  // Next state, counters and row storage.
  always_comb begin
    st_d  = st_q;
    row_d = row_q;
    t_d   = t_q;
    a_d   = a_q;
    b_d   = b_q;

    if (load_fire) begin
      for (int r = 0; r < N; r++) begin
        if (row_q == CW'(r)) begin
          a_d[r*RW +: RW] = load_row_a;
          b_d[r*RW +: RW] = load_row_b;
        end
      end
    end

    case (st_q)
      ST_IDLE: begin
        if (load_fire) begin
          st_d  = ST_LOAD;
          row_d = row_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_fire) begin
          if (row_q == LAST_ROW) begin
            st_d  = ST_FEED;
            row_d = '0;
            t_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (t_q == T_LAST) begin
          st_d = ST_DRAIN;
          t_d  = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (t_q == LAST_ROW) begin
          st_d  = ST_IDLE;
          t_d   = '0;
          row_d = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        row_d = '0;
        t_d   = '0;
      end
    endcase
  end

  // Lanes look at next-cycle matrix and time so the registered outputs line
  // up with FEED t, including the last row written on the FEED-entry edge.
  for (genvar k = 0; k < N; k++) begin : g_lane
    VX_sau_diag_sel #(
      .N  (N),
      .DW (DW),
      .K  (k),
      .CW (CW)
    ) u_sel (
      .a_mat  (a_d),
      .b_mat  (b_d),
      .t      (t_d),
      .a_lane (sel_a[k*DW +: DW]),
      .b_lane (sel_b[k*DW +: DW])
    );
  end

  always_comb begin
    feed_valid_d = (st_d == ST_FEED);
    busy_d       = (st_d != ST_IDLE);
    done_d       = (st_q == ST_DRAIN) && (st_d == ST_IDLE);
    in_a_d       = feed_valid_d ? sel_a : '0;
    in_b_d       = feed_valid_d ? sel_b : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= ST_IDLE;
      row_q        <= '0;
      t_q          <= '0;
      in_a_q       <= '0;
      in_b_q       <= '0;
      feed_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      row_q        <= row_d;
      t_q          <= t_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
      feed_valid_q <= feed_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Matrix contents are don't-care after reset, so storage has no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_a       = in_a_q;
  assign in_b       = in_b_q;
  assign feed_valid = feed_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SAU_FEEDER_PERF_EN
  // Occupancy includes the cycle the first beat is accepted from IDLE, so a
  // back-to-back operation counts N load + 2N-1 feed + N drain cycles.
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((st_q != ST_IDLE) || load_fire) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_busy_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vx_sau_feeder.sv
// Purpose : self-checking bench for vx_sau_feeder at N=3, DATA_SIZE=8.
// Latency : n/a.
// Backpressure : n/a.
module tb_vx_sau_feeder;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_row_a = '0;
  logic [W-1:0] load_row_b = '0;
  logic         load_ready;
  logic [W-1:0] in_a, in_b;
  logic         feed_valid, busy, done;
`ifdef SAU_FEEDER_PERF_EN
  logic [31:0]  perf_busy_cycles;
  logic [31:0]  perf_start;
`endif

  vx_sau_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_row_a (load_row_a),
    .load_row_b (load_row_b),
    .in_a       (in_a),
    .in_b       (in_b),
    .feed_valid (feed_valid),
    .busy       (busy),
    .done       (done)
`ifdef SAU_FEEDER_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_e;
  int A[N][N];
  int B[N][N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_mats(input int abase, input int bbase);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        A[r][c] = abase + r*N + c;
        B[r][c] = bbase + r*N + c;
      end
    end
  endtask

  // Drive one row pair (or an idle/junk cycle when lv is 0).
  task automatic drive_row(input int r, input logic lv);
    load_valid = lv;
    for (int c = 0; c < N; c++) begin
      load_row_a[c*DW +: DW] = 8'(A[r][c]);
      load_row_b[c*DW +: DW] = 8'(B[r][c]);
    end
  endtask

  // Expected wavefronts for the matrices currently held in A/B.
  task automatic push_expected();
    logic [W-1:0] ea, eb;
    for (int t = 0; t <= 2*N-2; t++) begin
      ea = '0;
      eb = '0;
      for (int k = 0; k < N; k++) begin
        if (t - k >= 0 && t - k < N) begin
          ea[k*DW +: DW] = 8'(A[k][t-k]);
          eb[k*DW +: DW] = 8'(B[t-k][k]);
        end
      end
      exp_q.push_back({eb, ea});
    end
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 30) begin
      step();
      cycles++;
    end
    check(tag, done, 1'b1);
  endtask

  // Scoreboard side: every wavefront is compared against the oldest expectation.
  always @(negedge clk) begin
    if (feed_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("in_a", in_a, exp_e[W-1:0]);
        check("in_b", in_b, exp_e[2*W-1:W]);
      end
    end else begin
      check("in_a_zero", in_a, '0);
      check("in_b_zero", in_b, '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;

    // Reset state
    repeat (3) step();
    check("rst_feed_valid", feed_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    step();
    check("post_rst_load_ready", load_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // Three consecutive beats, then full FEED/DRAIN timing
    set_mats(1, 10);
    for (int r = 0; r < N; r++) begin
      check("load_ready_beat", load_ready, 1'b1);
      drive_row(r, 1'b1);
      if (r == N-1) push_expected();
      step();
    end
    // Junk offered during FEED/DRAIN must be neither stored nor acknowledged.
    load_valid = 1'b1;
    load_row_a = '1;
    load_row_b = '1;
    for (int i = 0; i < 2*N-1; i++) begin
      check("feed_valid_feed", feed_valid, 1'b1);
      check("load_ready_feed", load_ready, 1'b0);
      check("busy_feed", busy, 1'b1);
      step();
    end
    for (int i = 0; i < N; i++) begin
      check("feed_valid_drain", feed_valid, 1'b0);
      check("busy_drain", busy, 1'b1);
      check("done_drain", done, 1'b0);
      check("load_ready_drain", load_ready, 1'b0);
      step();
    end
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("load_ready_done", load_ready, 1'b1);

    // Back-to-back start in the done cycle, with stalls 1,0,0,1,1
    set_mats(30, 60);
    begin
      logic [4:0] pat;
      int r;
      pat = 5'b11001;
      r = 0;
      for (int i = 0; i < 5; i++) begin
        drive_row(r, pat[i]);
        if (pat[i]) begin
          r++;
          if (r == N) push_expected();
        end
        step();
        if (i == 0) check("done_one_cycle", done, 1'b0);
        if (i < 4) begin
          check("stall_no_feed", feed_valid, 1'b0);
          check("stall_load_ready", load_ready, 1'b1);
        end
      end
    end
    check("stall_feed_start", feed_valid, 1'b1);
    load_valid = 1'b0;
    wait_done("stall_done_seen", cyc);
    step();

    // Full operation from IDLE: latency and occupancy counter
    set_mats(100, 200);
`ifdef SAU_FEEDER_PERF_EN
    perf_start = perf_busy_cycles;
`endif
    for (int r = 0; r < N; r++) begin
      drive_row(r, 1'b1);
      if (r == N-1) push_expected();
      step();
    end
    load_valid = 1'b0;
    wait_done("op3_done_seen", cyc);
    check("op3_feed_to_done", cyc, (2*N-1) + N);
`ifdef SAU_FEEDER_PERF_EN
    check("perf_busy_cycles", perf_busy_cycles - perf_start, 32'd11);
`endif
    check("sb_empty", exp_q.size(), 0);
    step();

    // Reset in the middle of FEED aborts without a done pulse
    set_mats(1, 10);
    for (int r = 0; r < N; r++) begin
      drive_row(r, 1'b1);
      if (r == N-1) push_expected();
      step();
    end
    load_valid = 1'b0;
    step();
    step();
    check("abort_at_t2", feed_valid, 1'b1);
    reset = 1'b1;
    step();
    exp_q.delete();
    check("abort_feed_valid", feed_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_load_ready", load_ready, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3*N; i++) begin
      step();
      check("abort_no_done", done, 1'b0);
      check("abort_idle_busy", busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
